spi_register_bridge: RTL



---
 rtl/spi_register_bridge.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_register_bridge.sv
// spi_register_bridge
// SPI mode-0 peripheral that deserialises 24-bit register-write frames
// (16-bit register number, then 8-bit value, MSB first) and drives a single-cycle
// register-write port. All SPI pins are oversampled in the i_Clock domain.
//
// Optional feature: define SPI_BURST_EN to keep writing after the first value.
// Each further complete byte in the same chip-select window is written to
// number+1, number+2, ... with 16-bit wrap. Without it, trailing bits are ignored.
module spi_register_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SpiSclk,
    input  logic        i_SpiCs_n,
    input  logic        i_SpiMosi,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterWriteNumber,
    output logic [7:0]  o_RegisterWriteValue,
    output logic        o_FrameError,
    output logic        o_Busy
);

`ifdef SPI_BURST_EN
    typedef enum logic [1:0] {StIdle, StHeader, StData, StBurst} state_e;
`else
    typedef enum logic [1:0] {StIdle, StHeader, StData, StDrain} state_e;
`endif

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;
    logic bit_take;

    // Shift each pin one stage deeper per clock; remember the previous sync outputs.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SpiSclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SpiCs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SpiMosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer flops; CS resets to deasserted so reset never looks like a frame start.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // Decode synchronized levels and single-cycle edge events.
    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_prev_q;
        cs_rise   = cs_s & ~cs_prev_q;
        cs_fall   = ~cs_s & cs_prev_q;
        // A CS rise in the same cycle as an SCLK edge ends the frame; the edge is dropped.
        bit_take  = sclk_rise & ~cs_rise;
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] number_sr_q, number_sr_d;
    logic [7:0]  value_sr_q, value_sr_d;
    logic [15:0] wr_number_q, wr_number_d;
    logic [7:0]  wr_value_q, wr_value_d;
    logic        wr_en_q, wr_en_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  value_next;

    // State register plus all frame datapath flops.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            number_sr_q <= '0;
            value_sr_q  <= '0;
            wr_number_q <= '0;
            wr_value_q  <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            number_sr_q <= number_sr_d;
            value_sr_q  <= value_sr_d;
            wr_number_q <= wr_number_d;
            wr_value_q  <= wr_value_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: CS rise always returns to idle, otherwise advance on bit counts.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d = StHeader;
                    end
                end
                StHeader: begin
                    if (bit_take && bit_cnt_q == 5'd15) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (bit_take && bit_cnt_q == 5'd23) begin
`ifdef SPI_BURST_EN
                        state_d = StBurst;
`else
                        state_d = StDrain;
`endif
                    end
                end
`ifdef SPI_BURST_EN
                StBurst: state_d = StBurst;
`else
                StDrain: state_d = StDrain;
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and registered strobes: shift bits, count them, load outputs, flag aborts.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        number_sr_d = number_sr_q;
        value_sr_d  = value_sr_q;
        wr_number_d = wr_number_q;
        wr_value_d  = wr_value_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        value_next  = {value_sr_q[6:0], mosi_s};

        if (cs_rise) begin
            // Abort is an error only if part of a header, value or burst byte arrived.
            unique case (state_q)
                StHeader: frame_err_d = (bit_cnt_q != 5'd0);
                StData:   frame_err_d = 1'b1;
`ifdef SPI_BURST_EN
                StBurst:  frame_err_d = (bit_cnt_q != 5'd0);
`else
                StDrain:  frame_err_d = 1'b0;
`endif
                default:  frame_err_d = 1'b0;
            endcase
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Nothing partial may leak into the next frame.
                    bit_cnt_d   = '0;
                    number_sr_d = '0;
                    value_sr_d  = '0;
                end
                StHeader: begin
                    if (bit_take) begin
                        number_sr_d = {number_sr_q[14:0], mosi_s};
                        bit_cnt_d   = bit_cnt_q + 5'd1;
                    end
                end
                StData: begin
                    if (bit_take) begin
                        value_sr_d = value_next;
                        if (bit_cnt_q == 5'd23) begin
                            wr_number_d = number_sr_q;
                            wr_value_d  = value_next;
                            wr_en_d     = 1'b1;
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
`ifdef SPI_BURST_EN
                StBurst: begin
                    if (bit_take) begin
                        value_sr_d = value_next;
                        if (bit_cnt_q == 5'd7) begin
                            // 16-bit add wraps FFFF to 0000 naturally.
                            wr_number_d = wr_number_q + 16'd1;
                            wr_value_d  = value_next;
                            wr_en_d     = 1'b1;
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
`else
                StDrain: begin
                    bit_cnt_d = bit_cnt_q;
                end
`endif
                default: bit_cnt_d = '0;
            endcase
        end
    end

    // Output drive: everything comes straight from flops.
    always_comb begin
        o_RegisterWriteEnable = wr_en_q;
        o_RegisterWriteNumber = wr_number_q;
        o_RegisterWriteValue  = wr_value_q;
        o_FrameError          = frame_err_q;
        o_Busy                = ~cs_s;
    end

endmodule
